// File: rtl/ex_mdu_if.sv
// Request/result handshake between the EX stage and the multiply/divide unit.
// master = issuing stage (drives request, flush, result ready), slave = ex_mdu.
interface ex_mdu_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [4:0]      rd_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;
  logic            illegal_o;

  modport master (
    output flush, valid_i, op_i, a_i, b_i, rd_i, ready_i,
    input  ready_o, valid_o, result_o, rd_o, illegal_o
  );

  modport slave (
    input  flush, valid_i, op_i, a_i, b_i, rd_i, ready_i,
    output ready_o, valid_o, result_o, rd_o, illegal_o
  );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV-style MUL/DIV unit; divider only built with EX_MDU_DIV_EN.
// Latency XLEN+1 cycles (2 for div-by-zero, overflow and illegal ops).
// Accepts only when idle; result held in DONE until ready_i or flush.
module ex_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic     clk,
  input logic     rst,
  ex_mdu_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic [1:0]      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] m_q;
  logic [XLEN-1:0] res_q;
  logic [2*XLEN:0] p_q;
  logic            neg_q, spec_q, ill_q;

  logic            is_div, a_sgnd, b_sgnd, a_neg, b_neg, neg_n;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            spec_n, ill_n;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    a_sgnd = 1'b0;
    b_sgnd = 1'b0;
    case (bus.op_i)
      3'd1, 3'd4, 3'd6: begin a_sgnd = 1'b1; b_sgnd = 1'b1; end
      3'd2:             a_sgnd = 1'b1;
      default:          ;
    endcase
  end

  assign is_div = bus.op_i[2];
  assign a_neg  = a_sgnd & bus.a_i[XLEN-1];
  assign b_neg  = b_sgnd & bus.b_i[XLEN-1];
  assign a_mag  = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag  = b_neg ? -bus.b_i : bus.b_i;
  // Remainder follows the dividend sign; quotient and product the xor of signs.
  assign neg_n  = (is_div && bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef EX_MDU_DIV_EN
  logic div_zero, div_ovf;
  assign div_zero = is_div && (bus.b_i == '0);
  assign div_ovf  = is_div && !bus.op_i[0] && (bus.b_i == '1) &&
                    (bus.a_i == {1'b1, {(XLEN-1){1'b0}}});
  assign spec_n   = div_zero | div_ovf;
  assign ill_n    = 1'b0;
  always_comb begin
    spec_res = '0;
    if (div_zero)     spec_res = bus.op_i[1] ? bus.a_i : '1;
    else if (div_ovf) spec_res = bus.op_i[1] ? '0 : bus.a_i;
  end
`else
  assign spec_n   = is_div;
  assign ill_n    = is_div;
  assign spec_res = '0;
`endif

  // p_q = {hi, lo}: hi accumulates product / partial remainder, lo holds multiplier / quotient.
  logic [XLEN:0]     hi, mul_add;
  logic [XLEN-1:0]   lo;
  logic [2*XLEN:0]   mul_p, p_n;
  logic [2*XLEN-1:0] mul_full, mul_fix;
  logic [XLEN-1:0]   mul_res, fin_res;

  assign hi       = p_q[2*XLEN:XLEN];
  assign lo       = p_q[XLEN-1:0];
  assign mul_add  = hi + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_p    = {mul_add, lo} >> 1;
  assign mul_full = p_n[2*XLEN-1:0];
  assign mul_fix  = neg_q ? -mul_full : mul_full;
  assign mul_res  = (op_q == 3'd0) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];

`ifdef EX_MDU_DIV_EN
  logic [XLEN:0]   sh, diff;
  logic [2*XLEN:0] div_p;
  logic [XLEN-1:0] div_raw, div_res;
  assign sh      = {hi[XLEN-1:0], lo[XLEN-1]};
  assign diff    = sh - {1'b0, m_q};
  assign div_p   = diff[XLEN] ? {sh, lo[XLEN-2:0], 1'b0} : {diff, lo[XLEN-2:0], 1'b1};
  assign p_n     = op_q[2] ? div_p : mul_p;
  assign div_raw = op_q[1] ? p_n[2*XLEN-1:XLEN] : p_n[XLEN-1:0];
  assign div_res = neg_q ? -div_raw : div_raw;
  assign fin_res = op_q[2] ? div_res : mul_res;
`else
  assign p_n     = mul_p;
  assign fin_res = mul_res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      m_q    <= '0;
      p_q    <= '0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.valid_i && !bus.flush) begin
            state  <= S_BUSY;
            cnt    <= '0;
            op_q   <= bus.op_i;
            rd_q   <= bus.rd_i;
            neg_q  <= neg_n;
            spec_q <= spec_n;
            ill_q  <= ill_n;
            res_q  <= spec_res;
            m_q    <= is_div ? b_mag : a_mag;
            p_q    <= {{(XLEN+1){1'b0}}, (is_div ? a_mag : b_mag)};
          end
        end
        S_BUSY: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else if (spec_q) begin
            state <= S_DONE;
          end else begin
            p_q <= p_n;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= S_DONE;
              res_q <= fin_res;
            end
          end
        end
        S_DONE: begin
          if (bus.flush || bus.ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o   = (state == S_IDLE);
  assign bus.valid_o   = (state == S_DONE);
  assign bus.result_o  = bus.valid_o ? res_q : '0;
  assign bus.rd_o      = bus.valid_o ? rd_q : '0;
  assign bus.illegal_o = bus.valid_o & ill_q;

endmodule
